ram_fifo_ctrl: RTL and testbench

//  Initiator-side controller for the team's simple dual-port RAM (sync write, registered 1-cycle read).

---
 rtl/memory_pkg.sv | 20 ++
 rtl/ram_fifo_obuf.sv | 48 ++++
 rtl/ram_fifo_ctrl.sv | 115 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the RAM-backed FIFO controller: default RAM geometry
// and a width helper usable in parameter and port declarations.
package memory_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 64;
   localparam int DEF_ADDR_W = 7;

   // Smallest r with 2**r >= v (0 for v <= 1).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // count spans 0..DEPTH+2 (RAM words plus in-flight read plus output buffer).
   localparam int DEF_CNT_W = clog2(DEF_DEPTH + 3);

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry in-order output buffer holding RAM read data ahead of the consumer.
// Latency: a push is visible at head_data/head_vld after the same clock edge.
// Backpressure: none internally; the controller never pushes into a full buffer.
module ram_fifo_obuf
   import memory_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        obuf_cnt,
   output logic              head_vld,
   output logic [DATA_W-1:0] head_data
);

   logic [DATA_W-1:0] tail_q;
   logic [1:0]        cnt_nxt;

   assign cnt_nxt = obuf_cnt + 2'(push) - 2'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obuf_cnt  <= '0;
         head_vld  <= 1'b0;
         head_data <= '0;
         tail_q    <= '0;
      end else begin
         obuf_cnt <= cnt_nxt;
         head_vld <= (cnt_nxt != 2'd0);
         if (pop) begin
            // Head leaves: promote tail if present, else take the arriving word.
            if (obuf_cnt == 2'd2) begin
               head_data <= tail_q;
               if (push) tail_q <= push_data;
            end else if (push) begin
               head_data <= push_data;
            end
         end else if (push) begin
            if (obuf_cnt == 2'd0) head_data <= push_data;
            else                  tail_q    <= push_data;
         end
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Stream FIFO controller over an external sync-write/1-cycle-read RAM; define RAM_FIFO_ALMOST_EN for almost_full/almost_empty.
// Latency: word accepted at edge N is presented at m_valid after edge N+2; 1 word/cycle sustained.
// Backpressure: s_ready drops when the RAM holds DEPTH words; m_ready low holds m_valid/m_data stable.
module ram_fifo_ctrl
   import memory_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int AFULL_TH  = 56,
   parameter int AEMPTY_TH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_W-1:0]           s_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [DATA_W-1:0]           m_data,
   output logic                        ram_we,
   output logic [ADDR_W-1:0]           ram_waddr,
   output logic [DATA_W-1:0]           ram_wdata,
   output logic [ADDR_W-1:0]           ram_raddr,
   input  logic [DATA_W-1:0]           ram_rdata,
   output logic [clog2(DEPTH+3)-1:0]   count
`ifdef RAM_FIFO_ALMOST_EN
   ,
   output logic                        almost_full,
   output logic                        almost_empty
`endif
);

   localparam int CNT_W = clog2(DEPTH + 3);
   localparam int MC_W  = clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [MC_W-1:0]   MEM_FULL  = MC_W'(DEPTH);

   if (DEPTH < 2 || (1 << ADDR_W) < DEPTH) begin : g_bad_geometry
      $error("ram_fifo_ctrl: DEPTH must be >= 2 and addressable with ADDR_W bits");
   end
   if (AFULL_TH > DEPTH + 2 || AEMPTY_TH > DEPTH + 2) begin : g_bad_threshold
      $error("ram_fifo_ctrl: almost thresholds exceed FIFO capacity");
   end

   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [MC_W-1:0]   mem_cnt;
   logic              inflight;
   logic [1:0]        obuf_cnt;
   logic              wr;
   logic              pop;
   logic              issue;
   logic [2:0]        pending;

   assign s_ready = (mem_cnt != MEM_FULL);
   assign wr      = s_valid && s_ready;
   assign pop     = m_valid && m_ready;

   // Read only when the word will have a buffer slot on arrival.
   assign pending = 3'(inflight) + 3'(obuf_cnt) - 3'(pop);
   assign issue   = (mem_cnt != '0) && (pending < 3'd2);

   assign ram_we    = wr;
   assign ram_waddr = wptr;
   assign ram_wdata = s_data;
   assign ram_raddr = rptr;

   assign count = CNT_W'(mem_cnt) + CNT_W'(inflight) + CNT_W'(obuf_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         mem_cnt  <= '0;
         inflight <= 1'b0;
      end else begin
         if (wr)    wptr <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
         if (issue) rptr <= (rptr == LAST_ADDR) ? '0 : rptr + 1'b1;
         inflight <= issue;
         if (wr && !issue)      mem_cnt <= mem_cnt + 1'b1;
         else if (!wr && issue) mem_cnt <= mem_cnt - 1'b1;
      end
   end

   ram_fifo_obuf #(
      .DATA_W (DATA_W)
   ) u_obuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (ram_rdata),
      .pop       (pop),
      .obuf_cnt  (obuf_cnt),
      .head_vld  (m_valid),
      .head_data (m_data)
   );

`ifdef RAM_FIFO_ALMOST_EN
   // Total occupancy only moves on the external handshakes.
   logic [CNT_W-1:0] count_nxt;
   assign count_nxt = count + CNT_W'(wr) - CNT_W'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (count_nxt >= CNT_W'(AFULL_TH));
         almost_empty <= (count_nxt <= CNT_W'(AEMPTY_TH));
      end
   end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl paired with a behavioural 1-cycle-read dual-port RAM.
module tb_ram_fifo_ctrl;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 7;
   localparam int CNT_W  = $clog2(DEPTH + 3);

   logic              clk;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [ADDR_W-1:0] ram_raddr;
   logic [DATA_W-1:0] ram_rdata;
   logic [CNT_W-1:0]  count;
`ifdef RAM_FIFO_ALMOST_EN
   logic              almost_full;
   logic              almost_empty;
`endif

   ram_fifo_ctrl #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .AFULL_TH(56), .AEMPTY_TH(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .ram_we    (ram_we),
      .ram_waddr (ram_waddr),
      .ram_wdata (ram_wdata),
      .ram_raddr (ram_raddr),
      .ram_rdata (ram_rdata),
      .count     (count)
`ifdef RAM_FIFO_ALMOST_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   // RAM: synchronous write, registered read returning the pre-write word.
   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
      ram_rdata <= ram[ram_raddr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DATA_W-1:0] exp_q [$];
   logic [ADDR_W-1:0] exp_wptr;
   logic              stall_prev;
   logic [DATA_W-1:0] stall_data;
   int checks;
   int errors;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Monitor: output scoreboard, stall stability, write-side address tracking.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_m_valid", m_valid, 1);
            chk("stall_m_data", m_data, stall_data);
         end
         stall_prev = m_valid && !m_ready;
         stall_data = m_data;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("pop_with_empty_model", exp_q.size(), 1);
            else                   chk("m_data_order", m_data, exp_q.pop_front());
         end
         if (s_valid && s_ready) begin
            chk("ram_we", ram_we, 1);
            chk("ram_waddr", ram_waddr, exp_wptr);
            chk("ram_wdata", ram_wdata, s_data);
            exp_q.push_back(s_data);
            exp_wptr = (exp_wptr == ADDR_W'(DEPTH - 1)) ? '0 : exp_wptr + 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      m_ready = 1'b0;
      rst_n   = 1'b0;
      exp_q.delete();
      exp_wptr = '0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      while ((count != 0 || exp_q.size() != 0) && n < 500) begin
         step();
         n++;
      end
      chk({name, "_drain_in_time"}, int'(n < 500), 1);
      chk({name, "_drained_m_valid"}, m_valid, 0);
      chk({name, "_drained_model"}, exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   int first_v, last_v, nval, srdy_low, k, sent, cyc;

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      m_ready = 1'b0;
      exp_wptr = '0;
      stall_prev = 1'b0;

      // 1: reset values, single word latency
      do_reset();
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_count", count, 0);
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hA5;
      step();
      s_valid = 1'b0;
      chk("t1_m_valid_n0", m_valid, 0);
      chk("t1_count_n0", count, 1);
      step();
      chk("t1_m_valid_n1", m_valid, 0);
      chk("t1_count_n1", count, 1);
      step();
      chk("t1_m_valid_n2", m_valid, 1);
      chk("t1_m_data_n2", m_data, 8'hA5);
      chk("t1_count_n2", count, 1);
      step();
      chk("t1_m_valid_n3", m_valid, 0);
      chk("t1_count_n3", count, 0);

      // 2: fill to capacity DEPTH+2 with consumer stalled, then drain
      m_ready = 1'b0;
      for (int i = 0; i < 66; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i);
         chk("t2_s_ready_open", s_ready, 1);
         step();
         chk("t2_count", count, i + 1);
      end
      chk("t2_full_s_ready", s_ready, 0);
      s_data = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_full_count_hold", count, 66);
         chk("t2_full_s_ready_hold", s_ready, 0);
      end
      drain("t2");

      // 3: continuous streaming, no bubbles
      m_ready = 1'b1;
      first_v = -1; last_v = -1; nval = 0; srdy_low = 0;
      for (int i = 0; i < 210; i++) begin
         s_valid = (i < 200);
         s_data  = 8'(i * 7);
         if (i < 200 && !s_ready) srdy_low++;
         step();
         if (m_valid) begin
            nval++;
            if (first_v < 0) first_v = i;
            last_v = i;
         end
      end
      chk("t3_first_valid_cycle", first_v, 2);
      chk("t3_valid_cycles", nval, 200);
      chk("t3_contiguous_span", last_v - first_v + 1, 200);
      chk("t3_s_ready_drops", srdy_low, 0);
      drain("t3");

      // 4: full FIFO with simultaneous push/pop across the address wrap
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 66; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h80 + i);
         step();
      end
      chk("t4_full_count", count, 66);
      chk("t4_full_s_ready", s_ready, 0);
      m_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 11; c++) begin
         s_data = 8'(8'hD0 + k);
         if (s_ready) k++;
         step();
         chk("t4_count_steady", count, 65);
      end
      chk("t4_words_accepted", k, 10);
      drain("t4");

      // 5: random handshakes, then reset in the middle of a burst
      sent = 0; cyc = 0;
      while (sent < 10000 && cyc < 40000) begin
         s_valid = ($urandom_range(3) != 0);
         s_data  = 8'($urandom);
         m_ready = ($urandom_range(3) != 0);
         if (s_valid && s_ready) sent++;
         step();
         cyc++;
      end
      chk("t5_words_sent", sent, 10000);
      drain("t5");
      m_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h30 + i);
         step();
      end
      chk("t5_pre_reset_m_valid", m_valid, 1);
      chk("t5_pre_reset_count", count, 20);
      s_valid = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      exp_wptr = '0;
      #1;
      chk("t5_rst_s_ready", s_ready, 1);
      chk("t5_rst_m_valid", m_valid, 0);
      chk("t5_rst_m_data", m_data, 0);
      chk("t5_rst_ram_we", ram_we, 0);
      chk("t5_rst_count", count, 0);
      step();
      rst_n = 1'b1;
      step();
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'h3C;
      step();
      s_valid = 1'b0;
      step();
      step();
      step();
      chk("t5_post_reset_delivered", exp_q.size(), 0);
      chk("t5_post_reset_count", count, 0);

`ifdef RAM_FIFO_ALMOST_EN
      // 6: almost flags track occupancy across both thresholds
      do_reset();
      chk("t6_rst_almost_full", almost_full, 0);
      chk("t6_rst_almost_empty", almost_empty, 1);
      m_ready = 1'b0;
      k = 0;
      for (int i = 0; i < 66; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i);
         if (s_ready) k++;
         step();
         chk("t6_fill_almost_full", almost_full, int'(k >= 56));
         chk("t6_fill_almost_empty", almost_empty, int'(k <= 8));
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 70; i++) begin
         if (m_valid) k--;
         step();
         chk("t6_drain_almost_full", almost_full, int'(k >= 56));
         chk("t6_drain_almost_empty", almost_empty, int'(k <= 8));
      end
      chk("t6_final_count", count, 0);
`endif

      chk("final_model_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
